// File: rtl/seq_cpu_pkg.sv
// Shared word width, opcode encodings and ALU helper for the byte-coded sequential CPU.
package seq_cpu_pkg;

    localparam int BITNESS = 16;
    typedef logic [BITNESS-1:0] word_t;

    // High-nibble opcode groups
    localparam logic [3:0] OPH_LDL  = 4'h0;
    localparam logic [3:0] OPH_LDH  = 4'h1;
    localparam logic [3:0] OPH_SETP = 4'h2;
    localparam logic [3:0] OPH_CLRP = 4'h3;
    localparam logic [3:0] OPH_OUT  = 4'h4;
    localparam logic [3:0] OPH_SKP  = 4'h6;
    localparam logic [3:0] OPH_ALU  = 4'h7;
    localparam logic [3:0] OPH_JMP  = 4'h8;
    localparam logic [3:0] OPH_HALT = 4'hF;

    // Full-byte opcodes
    localparam logic [7:0] OP_OUT   = 8'h40;
    localparam logic [7:0] OP_MOV   = 8'h70;
    localparam logic [7:0] OP_JMP   = 8'h80;
    localparam logic [7:0] OP_JZ    = 8'h81;
    localparam logic [7:0] OP_JNZ   = 8'h82;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    // pin_out bit roles
    localparam int PIN_STB  = 0;
    localparam int PIN_HALT = 1;

    function automatic logic [7:0] alu_op(input logic [2:0] f,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (f)
            3'd1:    alu_op = a + b;
            3'd2:    alu_op = a - b;
            3'd3:    alu_op = a & b;
            3'd4:    alu_op = a | b;
            3'd5:    alu_op = a ^ b;
            3'd6:    alu_op = a + 8'd1;
            3'd7:    alu_op = a - 8'd1;
            default: alu_op = a;
        endcase
    endfunction

endpackage

// File: rtl/seq_cpu_test_mem.sv
// 1 KiB read-only program store; contents are loaded from outside, reads are combinational.
module test_mem #(
    parameter int AW = seq_cpu_pkg::BITNESS
) (
    input  logic [AW-1:0] addr,
    output logic [7:0]    data
);
    logic [7:0] m [1024];

    assign data = m[addr[9:0]];

    if (AW > 10) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^addr[AW-1:10];
    end
endmodule

// File: rtl/seq_cpu.sv
// Single-cycle CPU: executes the byte at pc each clock; registered pin_out carries strobe, halt, char and GPIO.
module seq_cpu #(
    parameter int BITNESS = seq_cpu_pkg::BITNESS
) (
    input  logic               clk,
    input  logic               rst,
    output logic [BITNESS-1:0] m_addr,
    input  logic [7:0]         m_read,
    input  logic               pin_in  [BITNESS],
    output logic               pin_out [BITNESS],
    output logic [BITNESS-1:0] pc
);
    import seq_cpu_pkg::*;

    logic [BITNESS-1:0] pc_q, pc_d;
    logic [BITNESS-1:0] pout_q, pout_d;
    logic [BITNESS-1:0] pin_vec;
    logic [7:0]         a_q, a_d, b_q, b_d;
    logic               z_q, z_d;
    logic [3:0]         n;
    logic               n_ok, pin_bit;

    always_comb begin
        for (int i = 0; i < BITNESS; i++) begin
            pin_vec[i] = pin_in[i];
            pin_out[i] = pout_q[i];
        end
    end

    assign m_addr  = pc_q;
    assign pc      = pc_q;
    assign n       = m_read[3:0];
    // Pin numbers 0..15 are encodable, but only those below BITNESS exist.
    assign n_ok    = ({28'd0, n} < 32'(BITNESS));
    assign pin_bit = n_ok ? pin_vec[n] : 1'b0;

    always_comb begin
        pc_d   = pc_q;
        a_d    = a_q;
        b_d    = b_q;
        z_d    = z_q;
        pout_d = pout_q;
        // The strobe is a one-cycle pulse, also forced low while halted.
        pout_d[PIN_STB] = 1'b0;
        if (!pout_q[PIN_HALT]) begin
            pc_d = pc_q + BITNESS'(1);
            case (m_read[7:4])
                OPH_LDL:  a_d[3:0] = n;
                OPH_LDH:  a_d[7:4] = n;
                OPH_SETP: if (n_ok) pout_d[n] = 1'b1;
                OPH_CLRP: if (n_ok) pout_d[n] = 1'b0;
                OPH_OUT: begin
                    if (m_read == OP_OUT) begin
                        pout_d[9:2]     = a_q;
                        pout_d[PIN_STB] = 1'b1;
                    end
                end
                OPH_SKP:  if (!pin_bit) pc_d = pc_q + BITNESS'(2);
                OPH_ALU: begin
                    if (m_read == OP_MOV) begin
                        b_d = a_q;
                    end else if (!n[3]) begin
                        a_d = alu_op(n[2:0], a_q, b_q);
                        z_d = (a_d == 8'd0);
                    end
                end
                OPH_JMP: begin
                    if ((m_read == OP_JMP) || (m_read == OP_JZ && z_q) ||
                        (m_read == OP_JNZ && !z_q))
                        pc_d = BITNESS'(a_q);
                end
                OPH_HALT: if (m_read == OP_HALT) pout_d[PIN_HALT] = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            z_q    <= 1'b0;
            pout_q <= '0;
        end else begin
            pc_q   <= pc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            z_q    <= z_d;
            pout_q <= pout_d;
        end
    end
endmodule

// File: tb/tb_seq_cpu.sv
// Scoreboard bench: an instruction-level interpreter predicts pc/pin_out per cycle and emitted chars.
module tb_seq_cpu;
    localparam int BW   = 16;
    localparam int MAXC = 300;

    typedef struct {
        int            pc;
        logic [BW-1:0] po;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] m_addr, pc;
    logic [7:0]    m_read;
    logic          pin_in  [BW];
    logic          pin_out [BW];

    rec_t          exp_q[$];
    logic [7:0]    chr_q[$];
    logic [7:0]    got_q[$];
    logic [7:0]    prog[$];
    logic [7:0]    mem [1024];
    logic [BW-1:0] pins;
    int            total = 0;
    int            bad = 0;
    int            strobes = 0;
    bit            running = 1'b0;

    always #5 clk = ~clk;

    seq_cpu #(.BITNESS(BW)) dut (
        .clk(clk), .rst(rst), .m_addr(m_addr), .m_read(m_read),
        .pin_in(pin_in), .pin_out(pin_out), .pc(pc)
    );

    test_mem #(.AW(BW)) u_mem (.addr(m_addr), .data(m_read));

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [BW-1:0] pout_vec();
        logic [BW-1:0] v;
        for (int i = 0; i < BW; i++) v[i] = pin_out[i];
        return v;
    endfunction

    // Instruction-level interpreter over plain integers.
    task automatic model();
        int p = 0, a = 0, b = 0, z = 0, op, n, frozen = 0;
        bit jmp, skip;
        logic [BW-1:0] po = '0;
        rec_t r;
        for (int c = 0; c < MAXC; c++) begin
            r.pc = p;
            r.po = po;
            exp_q.push_back(r);
            if (po[1]) begin
                frozen++;
                if (frozen == 3) break;
                continue;
            end
            op = int'(mem[p % 1024]);
            n = op % 16;
            po[0] = 1'b0;
            jmp = 0;
            skip = 0;
            if (op < 'h10) a = (a & 'hF0) | n;
            else if (op < 'h20) a = (a & 'h0F) | (n << 4);
            else if (op < 'h30) po[n] = 1'b1;
            else if (op < 'h40) po[n] = 1'b0;
            else if (op == 'h40) begin
                for (int i = 0; i < 8; i++) po[i+2] = a[i];
                po[0] = 1'b1;
                chr_q.push_back(8'(a));
            end
            else if (op >= 'h60 && op < 'h70) skip = (pins[n] == 1'b0);
            else if (op == 'h70) b = a;
            else if (op > 'h70 && op < 'h78) begin
                case (op)
                    'h71: a = a + b;
                    'h72: a = a - b;
                    'h73: a = a & b;
                    'h74: a = a | b;
                    'h75: a = a ^ b;
                    'h76: a = a + 1;
                    default: a = a - 1;
                endcase
                a = a & 255;
                z = (a == 0);
            end
            else if (op == 'h80 || (op == 'h81 && z != 0) || (op == 'h82 && z == 0)) jmp = 1;
            else if (op == 'hFF) po[1] = 1'b1;
            p = jmp ? a : (p + (skip ? 2 : 1)) % 65536;
        end
    endtask

    task automatic start_prog(input logic [BW-1:0] pv);
        rst = 1'b1;
        running = 1'b0;
        exp_q.delete();
        chr_q.delete();
        got_q.delete();
        strobes = 0;
        pins = pv;
        for (int i = 0; i < BW; i++) pin_in[i] = pv[i];
        for (int i = 0; i < 1024; i++) begin
            mem[i] = (i < prog.size()) ? prog[i] : 8'h00;
            u_mem.m[i] = mem[i];
        end
        model();
        @(posedge clk);
        #1;
        chk("reset_pc", pc, 0);
        chk("reset_pin_out", pout_vec(), 0);
        rst = 1'b0;
        running = 1'b1;
    endtask

    task automatic finish_prog();
        for (int c = 0; c < MAXC + 10 && exp_q.size() != 0; c++) @(posedge clk);
        chk("trace_drained", exp_q.size(), 0);
        running = 1'b0;
        chk("chars_drained", chr_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (running) begin
            logic [BW-1:0] po;
            rec_t r;
            po = pout_vec();
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL trace_overrun: got extra cycle pc=%0h expected none", pc);
            end else begin
                r = exp_q.pop_front();
                chk("pc", pc, r.pc);
                chk("m_addr", m_addr, r.pc);
                chk("pin_out", po, r.po);
            end
            if (po[0]) begin
                strobes++;
                got_q.push_back(po[9:2]);
                if (chr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL char_unexpected: got %0h expected none", po[9:2]);
                end else chk("char", po[9:2], chr_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] by;
        bit seen;

        // "Hi" then halt
        prog = '{8'h08, 8'h14, 8'h40, 8'h09, 8'h16, 8'h40, 8'hFF};
        start_prog('0);
        finish_prog();
        chk("hi_strobes", strobes, 2);
        chk("hi_len", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("hi_c0", got_q[0], 8'h48);
            chk("hi_c1", got_q[1], 8'h69);
        end
        chk("hi_halt", pin_out[1], 1);
        chk("hi_pc", pc, 7);

        // SUB without zero, JZ not taken
        prog = '{8'h03, 8'h70, 8'h05, 8'h72, 8'h81, 8'hFF, 8'h00, 8'h03};
        start_prog('0);
        finish_prog();
        chk("sub_pc", pc, 6);
        chk("sub_halt", pin_out[1], 1);

        // DEC to zero, JZ taken
        prog = '{8'h01, 8'h77, 8'h05, 8'h81, 8'hFF, 8'hFF};
        start_prog('0);
        finish_prog();
        chk("jz_pc", pc, 6);

        // SKP not taken (pin0=1)
        prog = '{8'h60, 8'hFF, 8'h63, 8'hFF, 8'h2A, 8'hFF};
        start_prog(16'h0001);
        finish_prog();
        chk("skp_a_pc", pc, 2);
        chk("skp_a_p10", pin_out[10], 0);

        // SKP taken (pin3=0)
        prog = '{8'h60, 8'h00, 8'h63, 8'hFF, 8'h2A, 8'hFF};
        start_prog(16'h0001);
        finish_prog();
        chk("skp_b_pc", pc, 6);
        chk("skp_b_p10", pin_out[10], 1);

        // Reset mid-cycle after first OUT, then rerun
        prog = '{8'h08, 8'h14, 8'h40, 8'h09, 8'h16, 8'h40, 8'hFF};
        start_prog('0);
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clk);
            seen = (got_q.size() != 0);
        end
        chk("abort_first_out", seen, 1);
        #2;
        rst = 1'b1;
        running = 1'b0;
        #1;
        chk("abort_pc", pc, 0);
        chk("abort_m_addr", m_addr, 0);
        chk("abort_pin_out", pout_vec(), 0);
        start_prog('0);
        finish_prog();
        chk("rerun_len", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("rerun_c0", got_q[0], 8'h48);
            chk("rerun_c1", got_q[1], 8'h69);
        end
        chk("rerun_pc", pc, 7);

        // Random programs
        for (int t = 0; t < 20; t++) begin
            prog.delete();
            for (int i = 0; i < 48; i++) begin
                case ($urandom_range(0, 3))
                    0: by = 8'($urandom_range(0, 255));
                    1: by = 8'(8'h70 + $urandom_range(0, 7));
                    2: by = 8'h40;
                    default: by = 8'($urandom_range(0, 31));
                endcase
                prog.push_back(by);
            end
            prog.push_back(8'hFF);
            start_prog(16'($urandom_range(0, 65535)));
            finish_prog();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_cpu.md
SEQ_CPU -- requirements
Module: seq_cpu

Interface
REQ-001 SHALL have parameter BITNESS, default 16, giving the word width (minimum 10).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port m_addr, output, BITNESS bits: byte address to memory; combinational copy of pc.
REQ-005 SHALL have port m_read, input, 8 bits: byte at m_addr, valid in the same cycle.
REQ-006 SHALL have port pin_in, input, BITNESS x 1-bit unpacked array: general-purpose input pins.
REQ-007 SHALL have port pin_out, output, BITNESS x 1-bit unpacked array, registered: bit0 = char strobe, bit1 = halt, bits 9..2 = char data, others = GPIO.
REQ-008 SHALL have port pc, output, BITNESS bits: current program counter.

Function
- REQ-009 SHALL execute one 1-byte instruction per clock: fetch m_read at pc, update state at the next rising edge, pc <= pc+1 unless stated otherwise (wraps modulo 2^BITNESS).
- REQ-010 SHALL hold 8-bit registers A and B, plus zero flag Z; Z updates only on opcodes 0x71-0x77 and is 1 when the 8-bit result is 0.
- REQ-011 0x0n LDL: A[3:0] <= n. 0x1n LDH: A[7:4] <= n.
- REQ-012 0x2n SETP: pin_out[n] <= 1. 0x3n CLRP: pin_out[n] <= 0 (n = 0..15; no effect for n >= BITNESS).
- REQ-013 0x40 OUT: pin_out[9:2] <= A (bit i+2 = A[i]) and pin_out[0] <= 1 on the same edge.
- REQ-014 pin_out[0] SHALL be 1 only in the cycle after an OUT or SETP 0, and 0 in all other cycles; data bits hold until the next OUT.
- REQ-015 0x6n SKP: if pin_in[n] == 0, pc <= pc+2; otherwise pc <= pc+1.
- REQ-016 ALU opcodes, all results 8-bit with wrap-around and no carry flag:
  - 0x70 B <= A
  - 0x71 A <= A+B; 0x72 A <= A-B
  - 0x73 AND; 0x74 OR; 0x75 XOR, each of A with B into A
  - 0x76 A <= A+1; 0x77 A <= A-1
- REQ-017 0x80 JMP: pc <= zero-extended A. 0x81 JZ: jump to A if Z == 1. 0x82 JNZ: jump to A if Z == 0. Otherwise pc+1.
- REQ-018 0xFF HALT: pin_out[1] <= 1.
- REQ-019 While pin_out[1] == 1, pc and all registers SHALL freeze, no instruction SHALL execute, and pin_out[0] SHALL be 0.
- REQ-020 All other opcodes SHALL be NOP (pc+1 only).

Reset
- REQ-021 While rst == 1, regardless of clk: pc = 0, A = B = 0, Z = 0, every pin_out bit = 0.
- REQ-022 Reset asserted mid-execution SHALL abort immediately; the first fetch after release SHALL be from address 0.

Structure
- REQ-023 A shared package SHALL hold BITNESS, the WORD range macro/typedef, and the opcode constants.
- REQ-024 Sub-module test_mem(addr, data): 1024-byte array m, combinational read data = m[addr[9:0]], no write port.

Verification
- REQ-025 Program 08 14 40 09 16 40 FF:
  - strobe high exactly two cycles, with chars 'H' (0x48) then 'i' (0x69)
  - pin_out[1] = 1, pc frozen at 7
- REQ-026 Program 03 70 05 72 81 FF, then 0x03 at addr 7: A = 2, Z = 0, no jump; halts with pc frozen at 6.
- REQ-027 Program 01 77 05 81 FF FF: Z = 1, jump to address 5, halt with pc = 6.
- REQ-028 pin_in[0] = 1, pin_in[3] = 0:
  - program 60 FF 63 FF 2A FF: halts at address 1, pin_out[10] = 0
  - same program with byte 0 = 0x00: skips address 3, pin_out[10] = 1, halts at address 5
- REQ-029 rst pulsed at mid-cycle during REQ-025 after the first OUT: all outputs clear at once, and the program re-runs from pc 0 printing "Hi" again.
